// File: rtl/vga_pattern_ctrl.sv
// Frame-synchronous pattern selector for the 640x480 VGA path: a debounced button
// or a frame timer requests the next pattern, which is applied only at the frame boundary.
module vga_pattern_ctrl #(
  parameter int unsigned HMAX        = 799,
  parameter int unsigned VMAX        = 520,
  parameter int unsigned DB_CYCLES   = 250000,
  parameter int unsigned AUTO_FRAMES = 120
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_next,
  input  logic       auto_en,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       vidon,
  input  logic [7:0] rgb0,
  input  logic [7:0] rgb1,
  input  logic [7:0] rgb2,
  input  logic [7:0] rgb3,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic [1:0] sel,
  output logic       pending
);

  localparam int unsigned DB_W = $clog2(DB_CYCLES);
  localparam int unsigned FC_W = $clog2(AUTO_FRAMES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(AUTO_FRAMES - 1);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  logic            s1_q, s2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_level_q, db_level_d;
  logic            press_q, press_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic            fb, auto_adv;
  logic [7:0]      pix;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      press_q    <= 1'b0;
      fcnt_q     <= '0;
      state_q    <= RUN;
      sel_q      <= 2'd0;
    end else begin
      s1_q       <= btn_next;
      s2_q       <= s1_q;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      press_q    <= press_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      sel_q      <= sel_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (s2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_level_d = s2_q;
      db_cnt_d   = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    press_d = db_level_d & ~db_level_q;
  end

  assign fb       = (hc == 10'(HMAX)) && (vc == 10'(VMAX));
  assign auto_adv = fb && auto_en && (fcnt_q == FC_LAST);

  always_comb begin
    fcnt_d = fcnt_q;
    if (!auto_en || press_q) begin
      fcnt_d = '0;
    end else if (fb) begin
      fcnt_d = auto_adv ? '0 : fcnt_q + 1'b1;
    end
  end

  // A pending request and a timer advance on the same boundary collapse into one step.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      RUN: begin
        if (press_q)  state_d = PEND;
        if (auto_adv) sel_d   = sel_q + 2'd1;
      end
      PEND: begin
        if (fb) begin
          sel_d   = sel_q + 2'd1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pix = 8'h00;
    unique case (sel_q)
      2'd0: pix = rgb0;
      2'd1: pix = rgb1;
      2'd2: pix = rgb2;
      2'd3: pix = rgb3;
      default: pix = 8'h00;
    endcase
    if (!vidon) pix = 8'h00;
  end

  assign red     = pix[7:5];
  assign green   = pix[4:2];
  assign blue    = pix[1:0];
  assign sel     = sel_q;
  assign pending = (state_q == PEND);

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Directed bench for vga_pattern_ctrl on a reduced 10x5 frame; the bench itself plays
// the timing generator so every frame position is known exactly.
module tb_vga_pattern_ctrl;
  localparam int HMAX = 9, VMAX = 4, DBC = 4, AF = 3;
  localparam int FRAME = (HMAX + 1) * (VMAX + 1);

  logic       clk = 1'b0;
  logic       clr, btn_next, auto_en, vidon;
  logic [9:0] hc, vc;
  logic [7:0] rgb0, rgb1, rgb2, rgb3;
  logic [2:0] red, green;
  logic [1:0] blue, sel;
  logic       pending;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;

  vga_pattern_ctrl #(.HMAX(HMAX), .VMAX(VMAX), .DB_CYCLES(DBC), .AUTO_FRAMES(AF)) dut (
    .clk(clk), .clr(clr), .btn_next(btn_next), .auto_en(auto_en),
    .hc(hc), .vc(vc), .vidon(vidon),
    .rgb0(rgb0), .rgb1(rgb1), .rgb2(rgb2), .rgb3(rgb3),
    .red(red), .green(green), .blue(blue), .sel(sel), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic set_pos(input int p);
    pos   = p;
    hc    = 10'(p % (HMAX + 1));
    vc    = 10'(p / (HMAX + 1));
    vidon = (hc < 10'd8) && (vc < 10'd3);
  endtask

  // Inputs change 1 time unit after the edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    set_pos((pos + 1) % FRAME);
    #1;
  endtask

  task automatic goto_pos(input int p);
    int guard = 0;
    while (pos != p && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    if (pos != p) begin
      n_checks++; n_fail++;
      $display("FAIL goto_pos: at %0d, wanted %0d", pos, p);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel); end
    n_checks++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", pending); end
    n_checks++;
    if ({red, green, blue} !== 8'h00) begin
      n_fail++; $display("FAIL reset_rgb: got %h want 00", {red, green, blue});
    end
    clr = 1'b0;
  endtask

  task automatic test_single_press();
    goto_pos(5);
    btn_next = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) begin
        n_checks++;
        if (pending !== 1'b0) begin n_fail++; $display("FAIL press_early: got %b want 0 at cycle 6", pending); end
      end
      if (k == 7) begin
        n_checks++;
        if (pending !== 1'b1) begin n_fail++; $display("FAIL press_latency: got %b want 1 at cycle 7", pending); end
      end
    end
    btn_next = 1'b0;
    goto_pos(FRAME - 1);
    n_checks++;
    if (sel !== 2'd0) begin n_fail++; $display("FAIL press_before_fb: sel %0d want 0", sel); end
    tick();
    n_checks++;
    if (sel !== 2'd1) begin n_fail++; $display("FAIL press_after_fb: sel %0d want 1", sel); end
    n_checks++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL press_pending_clr: got %b want 0", pending); end
    n_checks++;
    if ({red, green, blue} !== 8'hE0) begin
      n_fail++; $display("FAIL press_rgb_on: got %h want e0", {red, green, blue});
    end
    goto_pos(8);
    n_checks++;
    if (red !== 3'd0) begin n_fail++; $display("FAIL press_rgb_blank: red %0d want 0", red); end
  endtask

  task automatic test_bounce();
    logic saw_pend = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn_next = ((i / 2) % 2) == 0;
      tick();
      if (pending) saw_pend = 1'b1;
    end
    btn_next = 1'b0;
    repeat (10) begin
      tick();
      if (pending) saw_pend = 1'b1;
    end
    n_checks++;
    if (saw_pend !== 1'b0) begin n_fail++; $display("FAIL bounce_pending: saw %b want 0", saw_pend); end
    goto_pos(FRAME - 1);
    tick();
    n_checks++;
    if (sel !== 2'd1) begin n_fail++; $display("FAIL bounce_sel: sel %0d want 1", sel); end
  endtask

  task automatic test_double_press();
    goto_pos(1);
    btn_next = 1'b1; repeat (8) tick(); btn_next = 1'b0;
    n_checks++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL double_first: pending %b want 1", pending); end
    repeat (8) tick();
    btn_next = 1'b1; repeat (8) tick(); btn_next = 1'b0;
    repeat (8) tick();
    goto_pos(FRAME - 1);
    tick();
    n_checks++;
    if (sel !== 2'd2) begin n_fail++; $display("FAIL double_sel: sel %0d want 2", sel); end
    goto_pos(FRAME - 1);
    tick();
    n_checks++;
    if (sel !== 2'd2 || pending !== 1'b0) begin
      n_fail++; $display("FAIL double_noqueue: sel %0d pending %b want 2 0", sel, pending);
    end
  endtask

  task automatic test_reset_midframe();
    goto_pos(23);
    n_checks++;
    if (green !== 3'd7) begin n_fail++; $display("FAIL rst_pre_green: got %0d want 7", green); end
    #1 clr = 1'b1;
    #1;
    n_checks++;
    if (sel !== 2'd0 || pending !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: sel %0d pending %b want 0 0", sel, pending);
    end
    n_checks++;
    if ({red, green, blue} !== 8'h00) begin
      n_fail++; $display("FAIL rst_rgb: got %h want 00", {red, green, blue});
    end
    tick(); tick();
    #3 clr = 1'b0;
    goto_pos(0);
  endtask

  task automatic test_auto();
    logic [1:0] exp;
    auto_en = 1'b1;
    for (int f = 1; f <= 12; f++) begin
      goto_pos(FRAME - 1);
      tick();
      exp = 2'((f / 3) % 4);
      n_checks++;
      if (sel !== exp) begin n_fail++; $display("FAIL auto_frame%0d: sel %0d want %0d", f, sel, exp); end
    end
    goto_pos(FRAME - 1); tick();
    goto_pos(20);
    auto_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      goto_pos(FRAME - 1); tick();
    end
    n_checks++;
    if (sel !== 2'd0) begin n_fail++; $display("FAIL auto_hold: sel %0d want 0", sel); end
    auto_en = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      goto_pos(FRAME - 1);
      tick();
      exp = (f == 3) ? 2'd1 : 2'd0;
      n_checks++;
      if (sel !== exp) begin n_fail++; $display("FAIL auto_restart%0d: sel %0d want %0d", f, sel, exp); end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_collision();
    auto_en = 1'b1;
    goto_pos(2);
    btn_next = 1'b1; repeat (8) tick(); btn_next = 1'b0;
    repeat (10) tick();
    force dut.fcnt_q = 3'(AF - 1);
    goto_pos(FRAME - 1);
    tick();
    auto_en = 1'b0;
    release dut.fcnt_q;
    n_checks++;
    if (sel !== 2'd2) begin n_fail++; $display("FAIL collide_sel: sel %0d want 2", sel); end
    n_checks++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL collide_pending: got %b want 0", pending); end
    goto_pos(FRAME - 1);
    tick();
  endtask

  task automatic test_press_on_fb();
    goto_pos(FRAME - 7);
    btn_next = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL fbpress_pre: pending %b want 0", pending); end
    tick();
    n_checks++;
    if (sel !== 2'd2 || pending !== 1'b1) begin
      n_fail++; $display("FAIL fbpress_boundary: sel %0d pending %b want 2 1", sel, pending);
    end
    repeat (3) tick();
    btn_next = 1'b0;
    goto_pos(25);
    n_checks++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL fbpress_mid: pending %b want 1", pending); end
    goto_pos(FRAME - 1);
    tick();
    n_checks++;
    if (sel !== 2'd3 || pending !== 1'b0) begin
      n_fail++; $display("FAIL fbpress_next: sel %0d pending %b want 3 0", sel, pending);
    end
  endtask

  initial begin
    clr      = 1'b1;
    btn_next = 1'b0;
    auto_en  = 1'b0;
    rgb0 = 8'h00; rgb1 = 8'hE0; rgb2 = 8'h1C; rgb3 = 8'h03;
    set_pos(0);
    test_reset();
    test_single_press();
    test_bounce();
    test_double_press();
    test_reset_midframe();
    test_auto();
    test_collision();
    test_press_on_fb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_ctrl.md
# vga_pattern_ctrl

Frame-synchronous pattern controller for the 640x480 VGA path. It sits between the `vga_640x480` timing generator and up to four pattern generators, such as `vga_stripes`, and selects which generator drives the RGB pins. A debounced push-button or an automatic frame timer requests the next pattern. The switch is applied only at the frame boundary, so no frame ever shows two patterns.

## Interface
- HMAX, 799: last horizontal count of a line (hc range 0..HMAX).
- VMAX, 520: last vertical count of a frame (vc range 0..VMAX).
- DB_CYCLES, 250000: stable-input cycles for debounce (10 ms at 25 MHz); must be at least 2.
- AUTO_FRAMES, 120: frames per pattern in auto mode; must be at least 1.
- clk, in, 1: 25 MHz pixel clock (same clock as the timing generator).
- clr, in, 1: asynchronous, active-high reset.
- btn_next, in, 1: raw, asynchronous push-button; high = pressed.
- auto_en, in, 1: enables automatic advance; level, synchronous to clk.
- hc, in, 10: horizontal count from the timing generator.
- vc, in, 10: vertical count from the timing generator.
- vidon, in, 1: active-video flag from the timing generator.
- rgb0..rgb3, in, 8 each: pattern source colours, packed {red[2:0], green[2:0], blue[1:0]}.
- red, out, 3: selected red, forced to 0 when vidon=0.
- green, out, 3: selected green, forced to 0 when vidon=0.
- blue, out, 2: selected blue, forced to 0 when vidon=0.
- sel, out, 2: currently displayed pattern index (registered).
- pending, out, 1: an advance request is queued for the next frame boundary.

## Operation
- Input synchroniser: btn_next passes through 2 flops (s1, s2), both reset to 0.
- Debouncer:
  - Counter counts consecutive cycles where s2 differs from `db_level`; it clears whenever s2 equals `db_level`.
  - When the count reaches DB_CYCLES-1 with s2 still differing, `db_level` takes s2 and the counter clears.
  - `press` is a 1-cycle pulse on the 0->1 transition of `db_level`.
- Frame boundary: `fb` = (hc==HMAX && vc==VMAX), combinational, i.e. the last clock of each frame.
- Auto timer:
  - `fcnt` is ceil(log2(AUTO_FRAMES))+1 bits wide.
  - It increments on `fb` while auto_en=1.
  - On `fb` with fcnt==AUTO_FRAMES-1 it generates `auto_adv` and wraps to 0.
  - auto_en=0 holds fcnt at 0.
  - `press` also clears fcnt to 0.
- FSM, 2 states:
  - RUN (reset state): on `press` go to PEND and set pending=1. `fb` with `auto_adv`: sel <= sel+1 and stay in RUN.
  - PEND: on `fb`, sel <= sel+1, pending <= 0, go to RUN. Further presses in PEND are absorbed: one advance maximum per boundary, no queueing.
- sel arithmetic: 2-bit, wraps 3 -> 0.
- Simultaneous events:
  - PEND and `auto_adv` at the same `fb`: a single advance (+1, not +2).
  - `press` in the same cycle as `fb` while in RUN: enter PEND; the advance is applied at the following boundary.
- RGB mux: combinational from registered sel; rgb{sel} is gated by vidon.
- Reset: clr asserted at any time, including mid-frame, immediately forces these values:
  - sel=0, pending=0, state=RUN, fcnt=0;
  - debounce counter=0, db_level=0, s1=s2=0.
  - red/green/blue then follow rgb0 gated by vidon.

## Timing
- Button press to `press` pulse: 2 sync cycles + DB_CYCLES cycles.
- `press` to sel change: sel updates on the clock edge that ends the `fb` cycle. The new sel is therefore valid from hc=0, vc=0, which is blanking.
- RGB path: 0 cycles of latency; it is aligned with vidon, hsync and vsync as produced by the timing generator.
- sel never changes at any cycle other than an `fb` edge, except on reset.

## Test plan
Use test parameters HMAX=9, VMAX=4 (50-clock frame), DB_CYCLES=4, AUTO_FRAMES=3, with rgb0..rgb3 = 8'h00, 8'hE0, 8'h1C, 8'h03.
- Reset: pulse clr mid-frame with sel=2 -> sel=0 and pending=0 asynchronously; red/green/blue = 0 while vidon=0.
- Single press:
  - Stimulus: btn_next high for 10 cycles in mid-frame.
  - Required: pending=1 on cycle 7 after the rise (2 sync + 4 debounce + 1 state register); sel 0->1 at the next fb edge; red=3'b111 when vidon=1.
- Bounce rejection: toggle btn_next every 2 cycles for 20 cycles, then release -> no press pulse; sel and pending unchanged.
- Auto advance:
  - auto_en=1, no presses: sel goes 0->1->2->3->0 at frame ends 3, 6, 9 and 12.
  - Drop auto_en mid-run: sel holds and fcnt=0.
- Collision:
  - Press queued (PEND) and auto_adv at the same fb -> sel increments by exactly 1.
  - Second press while PEND -> still a single increment.
- Press on the fb cycle: force the press pulse in the fb cycle -> sel unchanged at that boundary, increments at the next one 50 cycles later; pending is high in between.
